// File: rtl/kmeans_pkg.sv
// Shared types and constants for the k-means clustering core and its sample loader.
package kmeans_pkg;

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned DIMS   = 6;
  localparam int unsigned SAMPS  = 128;
  localparam int unsigned ADDR_W = $clog2(SAMPS);
  localparam int unsigned DIM_W  = $clog2(DIMS);

  typedef logic [WIDTH-1:0]  elem_t;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DIM_W-1:0]  dim_t;
  typedef elem_t [DIMS-1:0]  row_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    HANDOFF,
    SERVE
  } loader_state_t;

endpackage

// File: rtl/kmeans_sample_loader_if.sv
// Valid/ready word stream carrying one dimension value per beat, last marks end of a sample.
interface kmeans_sample_loader_if;
  import kmeans_pkg::*;

  logic  s_valid_i;
  logic  s_ready_o;
  elem_t s_data_i;
  logic  s_last_i;

  modport master (output s_valid_i, output s_data_i, output s_last_i, input s_ready_o);
  modport slave  (input s_valid_i, input s_data_i, input s_last_i, output s_ready_o);

endinterface

// File: rtl/kmeans_row_buffer.sv
// SAMPS x row register file: one full-row write port, one combinational read port.
module kmeans_row_buffer
  import kmeans_pkg::*;
(
  input  logic  clk_i,
  input  logic  we,
  input  addr_t waddr,
  input  row_t  wrow,
  input  addr_t raddr,
  output row_t  rrow_c
);

  row_t mem_q [SAMPS];

  // Contents are intentionally not reset; only complete loads are ever handed off.
  always_ff @(posedge clk_i) begin
    if (we) mem_q[waddr] <= wrow;
  end

  assign rrow_c = mem_q[raddr];

endmodule

// File: rtl/kmeans_sample_loader.sv
// Packs streamed dimension words into sample rows, hands a full buffer to the
// k-means core with a start pulse, then serves rows until the core releases it.
module kmeans_sample_loader
  import kmeans_pkg::*;
(
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         load_i,
  kmeans_sample_loader_if.slave        strm,
  output logic                         start_o,
  input  addr_t                        addr_i,
  output row_t                         membus_o,
  input  logic                         release_i,
  output logic                         busy_o,
  output logic                         err_o
);

  loader_state_t         state_q, state_d;
  addr_t                 wr_ptr_q, wr_ptr_d;
  dim_t                  dim_cnt_q, dim_cnt_d;
  elem_t [DIMS-2:0]      staging_q, staging_d;
  logic                  err_d, ready_d, start_d, busy_d;
  logic                  hs, last_dim, we;
  row_t                  wrow;

  assign hs       = strm.s_valid_i & strm.s_ready_o;
  assign last_dim = (dim_cnt_q == dim_t'(DIMS - 1));
  assign wrow     = {strm.s_data_i, staging_q};

  // Next-state, counters and framing check.
  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    dim_cnt_d = dim_cnt_q;
    staging_d = staging_q;
    err_d     = err_o;
    we        = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_i) begin
          state_d   = LOAD;
          wr_ptr_d  = '0;
          dim_cnt_d = '0;
          err_d     = 1'b0;
        end
      end
      LOAD: begin
        if (hs) begin
          if (strm.s_last_i != last_dim) begin
            // Mis-framed sample: drop the partial row, keep the row slot.
            err_d     = 1'b1;
            dim_cnt_d = '0;
          end else if (last_dim) begin
            we        = 1'b1;
            dim_cnt_d = '0;
            if (wr_ptr_q == addr_t'(SAMPS - 1)) state_d = HANDOFF;
            else                                wr_ptr_d = wr_ptr_q + addr_t'(1);
          end else begin
            staging_d[dim_cnt_q] = strm.s_data_i;
            dim_cnt_d            = dim_cnt_q + dim_t'(1);
          end
        end
      end
      HANDOFF: state_d = SERVE;
      SERVE: begin
        if (release_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == LOAD);
    start_d = (state_d == HANDOFF);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      dim_cnt_q     <= '0;
      err_o         <= 1'b0;
      start_o       <= 1'b0;
      busy_o        <= 1'b0;
      strm.s_ready_o <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      dim_cnt_q     <= dim_cnt_d;
      err_o         <= err_d;
      start_o       <= start_d;
      busy_o        <= busy_d;
      strm.s_ready_o <= ready_d;
    end
  end

  // Staging words are always overwritten before use.
  always_ff @(posedge clk_i) begin
    staging_q <= staging_d;
  end

  kmeans_row_buffer u_row_buffer (
    .clk_i  (clk_i),
    .we     (we),
    .waddr  (wr_ptr_q),
    .wrow   (wrow),
    .raddr  (addr_i),
    .rrow_c (membus_o)
  );

endmodule

// File: tb/tb_kmeans_sample_loader.sv
// Self-checking bench for kmeans_sample_loader: table reads, scripted corner cases, random loads vs model.
module tb_kmeans_sample_loader;
  import kmeans_pkg::*;

  logic  clk_i = 1'b0;
  logic  rst_i, load_i, release_i;
  addr_t addr_i;
  row_t  membus_o;
  logic  start_o, busy_o, err_o;

  kmeans_sample_loader_if strm();

  kmeans_sample_loader dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (load_i),
    .strm      (strm.slave),
    .start_o   (start_o),
    .addr_i    (addr_i),
    .membus_o  (membus_o),
    .release_i (release_i),
    .busy_o    (busy_o),
    .err_o     (err_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  int exp_starts = 0;

  always @(posedge clk_i) if (start_o === 1'b1) start_cnt <= start_cnt + 1;

  // Reference model: rows committed so far, words of the sample in progress, sticky error.
  int unsigned mdl_mem [SAMPS][DIMS];
  int unsigned partial [$];
  int          mdl_rows;
  bit          mdl_err;

  typedef struct {
    addr_t addr;
    row_t  exp;
  } rd_vec_t;
  rd_vec_t tbl [6];

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkr(input string name, input row_t act, input row_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: addr %0d got %h expected %h", name, addr_i, act, exp);
    end
  endtask

  function automatic void model_begin();
    mdl_rows = 0;
    mdl_err  = 1'b0;
    partial.delete();
  endfunction

  // A sample is clean only if last arrives exactly on its DIMS-th word.
  function automatic void model_word(input elem_t d, input bit l);
    partial.push_back(int'(d));
    if (l != (partial.size() == DIMS)) begin
      mdl_err = 1'b1;
      partial.delete();
    end else if (l) begin
      for (int k = 0; k < DIMS; k++) mdl_mem[mdl_rows][k] = partial[k];
      mdl_rows++;
      partial.delete();
    end
  endfunction

  function automatic row_t mdl_row(input int a);
    row_t r;
    for (int k = 0; k < DIMS; k++) r[k] = elem_t'(mdl_mem[a][k]);
    return r;
  endfunction

  function automatic row_t pat_row(input int base, input int a);
    row_t r;
    for (int k = 0; k < DIMS; k++) r[k] = elem_t'(base + a * DIMS + k);
    return r;
  endfunction

  task automatic stream_word(input elem_t d, input bit l, input bit gaps);
    int guard;
    guard = 0;
    if (gaps) begin
      while ($urandom_range(0, 2) == 0) begin
        strm.s_valid_i = 1'b0;
        step();
      end
    end
    strm.s_valid_i = 1'b1;
    strm.s_data_i  = d;
    strm.s_last_i  = l;
    while (strm.s_ready_o !== 1'b1 && guard < 50) begin
      step();
      guard++;
    end
    if (strm.s_ready_o !== 1'b1) begin
      chk1("ready_timeout", strm.s_ready_o, 1'b1);
      strm.s_valid_i = 1'b0;
      return;
    end
    step();
    strm.s_valid_i = 1'b0;
    model_word(d, l);
  endtask

  task automatic load_rows(input int base, input int r0, input int r1, input bit gaps);
    for (int r = r0; r < r1; r++)
      for (int k = 0; k < DIMS; k++)
        stream_word(elem_t'(base + r * DIMS + k), k == DIMS - 1, gaps);
  endtask

  task automatic begin_load();
    load_i = 1'b1;
    step();
    load_i = 1'b0;
    model_begin();
    chk1("load_busy", busy_o, 1'b1);
    chk1("load_ready", strm.s_ready_o, 1'b1);
    chk1("load_err_clear", err_o, 1'b0);
  endtask

  // Called the cycle after the final word's handshake edge.
  task automatic finish_load();
    chki("model_rows", mdl_rows, SAMPS);
    chk1("start_pulse", start_o, 1'b1);
    chk1("handoff_ready", strm.s_ready_o, 1'b0);
    chk1("handoff_busy", busy_o, 1'b1);
    step();
    exp_starts++;
    chk1("start_single", start_o, 1'b0);
    chk1("serve_ready", strm.s_ready_o, 1'b0);
    chk1("serve_busy", busy_o, 1'b1);
    chki("start_count", start_cnt, exp_starts);
  endtask

  task automatic release_buf();
    release_i = 1'b1;
    step();
    release_i = 1'b0;
    chk1("release_busy", busy_o, 1'b0);
    chk1("idle_ready", strm.s_ready_o, 1'b0);
  endtask

  // One address per cycle, compared before the next edge.
  task automatic sweep(input string name, input bit use_pat, input int base);
    for (int a = 0; a < SAMPS; a++) begin
      addr_i = addr_t'(a);
      #1;
      chkr(name, membus_o, use_pat ? pat_row(base, a) : mdl_row(a));
      step();
    end
  endtask

  task automatic rand_load();
    int guard;
    bit l;
    guard = 0;
    while (mdl_rows < SAMPS && guard < 5000) begin
      l = (partial.size() == DIMS - 1);
      if ($urandom_range(0, 39) == 0) l = !l;
      stream_word(elem_t'($urandom), l, 1'b1);
      guard++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0].addr = addr_t'(0);   tbl[0].exp = pat_row(0, 0);
    tbl[1].addr = addr_t'(1);   tbl[1].exp = pat_row(0, 1);
    tbl[2].addr = addr_t'(5);
    tbl[2].exp  = {16'd35, 16'd34, 16'd33, 16'd32, 16'd31, 16'd30};
    tbl[3].addr = addr_t'(63);  tbl[3].exp = pat_row(0, 63);
    tbl[4].addr = addr_t'(126); tbl[4].exp = pat_row(0, 126);
    tbl[5].addr = addr_t'(127); tbl[5].exp = pat_row(0, 127);

    rst_i = 1'b1; load_i = 1'b0; release_i = 1'b0; addr_i = '0;
    strm.s_valid_i = 1'b0; strm.s_data_i = '0; strm.s_last_i = 1'b0;
    repeat (3) step();
    rst_i = 1'b0;
    chk1("rst_busy", busy_o, 1'b0);
    chk1("rst_ready", strm.s_ready_o, 1'b0);
    chk1("rst_err", err_o, 1'b0);
    chk1("rst_start", start_o, 1'b0);

    // Full pattern load, then table-driven reads.
    begin_load();
    load_rows(0, 0, SAMPS, 1'b0);
    finish_load();
    for (int i = 0; i < 6; i++) begin
      addr_i = tbl[i].addr;
      #1;
      chkr("rd_tbl", membus_o, tbl[i].exp);
      step();
    end
    release_buf();

    // Same pattern with random valid gaps must give an identical buffer.
    step();
    chk1("idle_ready2", strm.s_ready_o, 1'b0);
    begin_load();
    load_rows(0, 0, SAMPS, 1'b1);
    finish_load();
    sweep("gap_rd", 1'b1, 0);
    release_buf();

    // Framing error at dim 3 of row 10; row 10 refilled by the next clean sample.
    begin_load();
    load_rows(0, 0, 10, 1'b0);
    for (int k = 0; k < 4; k++) stream_word(elem_t'(9000 + k), k == 3, 1'b0);
    chk1("frame_err", err_o, 1'b1);
    load_rows(0, 10, SAMPS, 1'b0);
    finish_load();
    chk1("err_sticky", err_o, 1'b1);
    for (int a = 9; a < 12; a++) begin
      addr_i = addr_t'(a);
      #1;
      chkr("err_rows", membus_o, pat_row(0, a));
      step();
    end

    // load_i alone in SERVE is ignored; load_i with release_i only returns to IDLE.
    load_i = 1'b1;
    repeat (3) begin
      step();
      chk1("serve_hold_busy", busy_o, 1'b1);
      chk1("serve_hold_ready", strm.s_ready_o, 1'b0);
    end
    release_i = 1'b1;
    step();
    load_i = 1'b0; release_i = 1'b0;
    chk1("rel_load_busy", busy_o, 1'b0);
    chk1("rel_load_ready", strm.s_ready_o, 1'b0);
    chk1("err_held_idle", err_o, 1'b1);
    step();
    chk1("idle_stays", busy_o, 1'b0);

    // Random data, random gaps and random framing errors against the model.
    begin_load();
    rand_load();
    finish_load();
    chk1("rand_err", err_o, mdl_err);
    sweep("rand_rd", 1'b0, 0);
    release_buf();

    // Reset in the middle of a load at row 64.
    begin_load();
    stream_word(elem_t'(4444), 1'b1, 1'b0);
    load_rows(1000, 0, 64, 1'b0);
    stream_word(elem_t'(1), 1'b0, 1'b0);
    stream_word(elem_t'(2), 1'b0, 1'b0);
    chk1("pre_rst_err", err_o, 1'b1);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    chk1("mid_rst_busy", busy_o, 1'b0);
    chk1("mid_rst_ready", strm.s_ready_o, 1'b0);
    chk1("mid_rst_err", err_o, 1'b0);
    chk1("mid_rst_start", start_o, 1'b0);
    repeat (3) step();
    chki("mid_rst_no_start", start_cnt, exp_starts);
    begin_load();
    load_rows(2000, 0, SAMPS, 1'b1);
    finish_load();
    sweep("fresh_rd", 1'b0, 0);
    release_buf();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
